// File: rtl/ov7670_capture.sv
// OV7670 YUV422 capture: keeps luma, decimates by 2^DECIM_LOG2 per axis, writes a linear frame buffer.
// Optional frame geometry checker enabled by defining OV_FRAME_CHECK_EN (adds frame_err output).
module ov7670_capture #(
    parameter int unsigned H_ACTIVE   = 640,
    parameter int unsigned V_ACTIVE   = 480,
    parameter int unsigned DECIM_LOG2 = 2,
    parameter int unsigned Y_FIRST    = 0,
    parameter int unsigned ADDR_W     = 16
) (
    input  logic              clk_50,
    input  logic              rst,
    input  logic              capture_en,
    input  logic              cam_pclk,
    input  logic              cam_href,
    input  logic              cam_vsync,
    input  logic [7:0]        cam_d,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_data,
    output logic              frame_done,
    output logic              busy
`ifdef OV_FRAME_CHECK_EN
    ,
    output logic              frame_err
`endif
);

    localparam int unsigned XW    = $clog2(H_ACTIVE + 1);
    localparam int unsigned YW    = $clog2(V_ACTIVE + 2);
    localparam int unsigned DMASK = (1 << DECIM_LOG2) - 1;

    localparam logic [XW-1:0]     X_LIM    = XW'(H_ACTIVE);
    localparam logic [XW-1:0]     X_MASK   = XW'(DMASK);
    localparam logic [YW-1:0]     Y_LIM    = YW'(V_ACTIVE);
    localparam logic [YW-1:0]     Y_SAT    = YW'(V_ACTIVE + 1);
    localparam logic [YW-1:0]     Y_MASK   = YW'(DMASK);
    localparam logic [ADDR_W-1:0] MAX_ADDR = ADDR_W'((H_ACTIVE * V_ACTIVE >> (2 * DECIM_LOG2)) - 1);
    localparam logic              YF       = (Y_FIRST != 0);

    typedef enum logic {StWaitSync, StCapture} state_e;

    state_e state_q, state_d;

    logic [1:0] pclk_s, href_s, vsync_s;
    logic [7:0] d_s1, d_s2;
    logic       pclk_s3;
    // Retimed copies: one extra stage so the write lands 3 cycles after pclk is first sampled.
    logic       pe, href, vsync;
    logic [7:0] d;

    logic          href_prev, vsync_prev;
    logic          phase_q;
    logic [XW-1:0] x_q;
    logic [YW-1:0] y_q;

    logic          in_cap, href_fall, vsync_rise, vsync_fall;
    logic          cur_phase, y_byte, write_hit, start, frame_end;
    logic [XW-1:0] cur_x;

    always_ff @(posedge clk_50 or posedge rst) begin
        if (rst) begin
            pclk_s  <= '0;
            href_s  <= '0;
            vsync_s <= '0;
            d_s1    <= '0;
            d_s2    <= '0;
            pclk_s3 <= 1'b0;
            pe      <= 1'b0;
            href    <= 1'b0;
            vsync   <= 1'b0;
            d       <= '0;
        end else begin
            pclk_s  <= {pclk_s[0], cam_pclk};
            href_s  <= {href_s[0], cam_href};
            vsync_s <= {vsync_s[0], cam_vsync};
            d_s1    <= cam_d;
            d_s2    <= d_s1;
            pclk_s3 <= pclk_s[1];
            pe      <= pclk_s[1] & ~pclk_s3;
            href    <= href_s[1];
            vsync   <= vsync_s[1];
            d       <= d_s2;
        end
    end

    always_comb begin
        in_cap     = (state_q == StCapture);
        href_fall  = ~href & href_prev;
        vsync_rise = vsync & ~vsync_prev;
        vsync_fall = ~vsync & vsync_prev;
        cur_phase  = href_prev ? phase_q : 1'b0;
        cur_x      = href_prev ? x_q : '0;
        y_byte     = cur_phase ^ YF;
        write_hit  = in_cap & pe & href & y_byte
                   & ((cur_x & X_MASK) == '0) & ((y_q & Y_MASK) == '0)
                   & (cur_x < X_LIM) & (y_q < Y_LIM);
        start      = ~in_cap & pe & vsync_fall & capture_en;
        frame_end  = in_cap & pe & vsync_rise;

        state_d = state_q;
        unique case (state_q)
            StWaitSync: if (start)     state_d = StCapture;
            StCapture:  if (frame_end) state_d = StWaitSync;
            default:                   state_d = StWaitSync;
        endcase
    end

    assign busy = in_cap;

    always_ff @(posedge clk_50 or posedge rst) begin
        if (rst) begin
            state_q    <= StWaitSync;
            href_prev  <= 1'b0;
            vsync_prev <= 1'b0;
            phase_q    <= 1'b0;
            x_q        <= '0;
            y_q        <= '0;
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            frame_done <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_en      <= write_hit;
            frame_done <= frame_end;
            if (pe) begin
                href_prev  <= href;
                vsync_prev <= vsync;
            end
            if (start) begin
                phase_q <= 1'b0;
                x_q     <= '0;
                y_q     <= '0;
                wr_addr <= '0;
            end else begin
                // Address advances the cycle after the strobe and saturates at the last pixel.
                if (wr_en && wr_addr != MAX_ADDR) wr_addr <= wr_addr + 1'b1;
                if (write_hit) wr_data <= d;
                if (in_cap && pe) begin
                    if (href) begin
                        phase_q <= ~cur_phase;
                        x_q     <= (cur_phase && cur_x != X_LIM) ? cur_x + 1'b1 : cur_x;
                    end else if (href_fall && y_q != Y_SAT) begin
                        y_q <= y_q + 1'b1;
                    end
                end
            end
        end
    end

`ifdef OV_FRAME_CHECK_EN
    localparam int unsigned BW = $clog2(2 * H_ACTIVE + 2);
    localparam logic [BW-1:0] B_LINE = BW'(2 * H_ACTIVE);
    localparam logic [BW-1:0] B_SAT  = BW'(2 * H_ACTIVE + 1);

    logic [BW-1:0] b_q, cur_b;
    logic          err_acc;

    assign cur_b = href_prev ? b_q : '0;

    always_ff @(posedge clk_50 or posedge rst) begin
        if (rst) begin
            b_q       <= '0;
            err_acc   <= 1'b0;
            frame_err <= 1'b0;
        end else if (start) begin
            b_q       <= '0;
            err_acc   <= 1'b0;
            frame_err <= 1'b0;
        end else if (in_cap && pe) begin
            if (href) b_q <= (cur_b == B_SAT) ? cur_b : cur_b + 1'b1;
            if (href_fall && b_q != B_LINE) err_acc <= 1'b1;
            if (frame_end) frame_err <= err_acc | (y_q != Y_LIM);
        end
    end
`endif

endmodule

// File: tb/tb_ov7670_capture.sv
// Randomized/directed bench for ov7670_capture with a pixel-level reference model.
module tb_ov7670_capture;

    localparam int H = 8;
    localparam int V = 8;

    logic clk_50 = 1'b0;
    logic rst = 1'b1;
    logic capture_en = 1'b0;
    logic cam_pclk = 1'b0, cam_href = 1'b0, cam_vsync = 1'b0;
    logic [7:0] cam_d = '0;

    logic        wr_en0, wr_en1, fd0, fd1, busy0, busy1;
    logic [15:0] wa0, wa1;
    logic [7:0]  wd0, wd1;
`ifdef OV_FRAME_CHECK_EN
    logic fe0, fe1;
`endif

    ov7670_capture #(.H_ACTIVE(H), .V_ACTIVE(V), .DECIM_LOG2(1), .Y_FIRST(0), .ADDR_W(16)) dut0 (
        .clk_50(clk_50), .rst(rst), .capture_en(capture_en), .cam_pclk(cam_pclk),
        .cam_href(cam_href), .cam_vsync(cam_vsync), .cam_d(cam_d), .wr_en(wr_en0),
        .wr_addr(wa0), .wr_data(wd0), .frame_done(fd0), .busy(busy0)
`ifdef OV_FRAME_CHECK_EN
        , .frame_err(fe0)
`endif
    );

    ov7670_capture #(.H_ACTIVE(H), .V_ACTIVE(V), .DECIM_LOG2(1), .Y_FIRST(1), .ADDR_W(16)) dut1 (
        .clk_50(clk_50), .rst(rst), .capture_en(capture_en), .cam_pclk(cam_pclk),
        .cam_href(cam_href), .cam_vsync(cam_vsync), .cam_d(cam_d), .wr_en(wr_en1),
        .wr_addr(wa1), .wr_data(wd1), .frame_done(fd1), .busy(busy1)
`ifdef OV_FRAME_CHECK_EN
        , .frame_err(fe1)
`endif
    );

    always #10 clk_50 = ~clk_50;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk_50) cyc <= cyc + 1;

    logic [15:0] ga0[$], ga1[$];
    logic [7:0]  gd0[$], gd1[$];
    int  fdn0, fdn1, first_cyc0, rise_cyc;
    bit  busy_seen0, fe_at_done0;
    logic [7:0] ypix[0:15][0:15];
    bit chroma_rand;

    always @(negedge clk_50) begin
        if (wr_en0) begin
            ga0.push_back(wa0);
            gd0.push_back(wd0);
            if (first_cyc0 < 0) first_cyc0 = cyc;
        end
        if (wr_en1) begin
            ga1.push_back(wa1);
            gd1.push_back(wd1);
        end
        if (fd0) begin
            fdn0++;
`ifdef OV_FRAME_CHECK_EN
            fe_at_done0 = fe0;
`endif
        end
        if (fd1) fdn1++;
        if (busy0) busy_seen0 = 1'b1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk_50);
        #1;
    endtask

    // One camera byte: data/href/vsync change while pclk is low, sampled on the pclk rise.
    task automatic pbyte(input logic [7:0] dv, input logic hv, input logic vv, input bit rec);
        cam_pclk = 1'b0; cam_d = dv; cam_href = hv; cam_vsync = vv;
        tick(2);
        cam_pclk = 1'b1;
        if (rec) rise_cyc = cyc;
        tick(2);
    endtask

    task automatic clear_obs();
        ga0.delete(); gd0.delete(); ga1.delete(); gd1.delete();
        fdn0 = 0; fdn1 = 0; first_cyc0 = -1; busy_seen0 = 1'b0; fe_at_done0 = 1'b0;
    endtask

    task automatic frame_start();
        repeat (3) pbyte(8'h00, 1'b0, 1'b1, 1'b0);
        repeat (3) pbyte(8'h00, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic draw_line(input int r, input int np, input bit yord);
        for (int c = 0; c < np; c++)
            for (int b = 0; b < 2; b++) begin
                bit is_y;
                is_y = yord ? (b == 0) : (b == 1);
                pbyte(is_y ? ypix[r][c] : (chroma_rand ? 8'($urandom) : 8'hAA), 1'b1, 1'b0,
                      is_y && r == 0 && c == 0);
            end
        repeat (3) pbyte(8'h00, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic frame_end();
        repeat (4) pbyte(8'h00, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic drive_frame(input int nl, input int np, input bit yord, input int drop_after);
        frame_start();
        for (int r = 0; r < nl; r++) begin
            draw_line(r, np, yord);
            if (r == drop_after) capture_en = 1'b0;
        end
        frame_end();
    endtask

    // Reference: every 2nd row and column inside the active window, raster order from 0.
    task automatic check_frame(input string tag, input bit which, input int nl, input int np,
                               input int exp_fd);
        logic [15:0] ea[$];
        logic [7:0]  ed[$];
        int a, n;
        a = 0;
        for (int r = 0; r < nl && r < V; r += 2)
            for (int c = 0; c < np && c < H; c += 2) begin
                ea.push_back(16'(a));
                ed.push_back(ypix[r][c]);
                a++;
            end
        n = which ? ga1.size() : ga0.size();
        chk({tag, "_count"}, n, ea.size());
        for (int i = 0; i < n && i < ea.size(); i++) begin
            chk({tag, "_addr"}, which ? ga1[i] : ga0[i], ea[i]);
            chk({tag, "_data"}, which ? gd1[i] : gd0[i], ed[i]);
        end
        chk({tag, "_done"}, which ? fdn1 : fdn0, exp_fd);
        chk({tag, "_busy_end"}, which ? busy1 : busy0, 1'b0);
    endtask

    initial begin
        for (int r = 0; r < 16; r++)
            for (int c = 0; c < 16; c++) ypix[r][c] = {r[3:0], c[3:0]};
        chroma_rand = 1'b0;
        clear_obs();

        tick(3);
        chk("rst_wr_en", wr_en0, 1'b0);
        chk("rst_wr_addr", wa0, 16'h0);
        chk("rst_wr_data", wd0, 8'h0);
        chk("rst_frame_done", fd0, 1'b0);
        chk("rst_busy", busy0, 1'b0);
        rst = 1'b0;
        capture_en = 1'b1;
        tick(2);

        // Full frame, UYVY order, Y = {row, col}
        clear_obs();
        drive_frame(8, 8, 1'b0, -1);
        check_frame("full", 1'b0, 8, 8, 1);
        chk("latency", first_cyc0, rise_cyc + 4);
`ifdef OV_FRAME_CHECK_EN
        chk("full_frame_err", fe_at_done0, 1'b0);
`endif

        // Same picture in YUYV order on the Y_FIRST=1 instance
        clear_obs();
        drive_frame(8, 8, 1'b1, -1);
        check_frame("yfirst", 1'b1, 8, 8, 1);
        begin
            int aa = 0;
            foreach (gd1[i]) if (gd1[i] == 8'hAA) aa++;
            chk("yfirst_no_chroma", aa, 0);
        end

        // Random luma and chroma
        for (int r = 0; r < 16; r++)
            for (int c = 0; c < 16; c++) ypix[r][c] = 8'($urandom);
        chroma_rand = 1'b1;
        clear_obs();
        drive_frame(8, 8, 1'b0, -1);
        check_frame("rand", 1'b0, 8, 8, 1);

        // Oversized frame: 10 pixels x 9 lines
        clear_obs();
        drive_frame(9, 10, 1'b0, -1);
        check_frame("oversize", 1'b0, 9, 10, 1);
        chk("oversize_max_addr", ga0.size() > 0 ? ga0[ga0.size()-1] : 16'hFFFF, 16'd15);
`ifdef OV_FRAME_CHECK_EN
        chk("oversize_frame_err", fe_at_done0, 1'b1);
`endif

        // capture_en dropped after line 3: frame completes, next one is skipped
        clear_obs();
        drive_frame(8, 8, 1'b0, 3);
        check_frame("en_drop", 1'b0, 8, 8, 1);
        clear_obs();
        drive_frame(8, 8, 1'b0, -1);
        chk("disabled_writes", ga0.size(), 0);
        chk("disabled_done", fdn0, 0);
        chk("disabled_busy", busy_seen0, 1'b0);
        capture_en = 1'b1;

        // Early vsync after 4 lines, then a clean frame restarting at 0
        clear_obs();
        drive_frame(4, 8, 1'b0, -1);
        check_frame("short", 1'b0, 4, 8, 1);
`ifdef OV_FRAME_CHECK_EN
        chk("short_frame_err", fe_at_done0, 1'b1);
`endif
        clear_obs();
        drive_frame(8, 8, 1'b0, -1);
        check_frame("after_short", 1'b0, 8, 8, 1);

        // Asynchronous reset while a write strobe is high
        clear_obs();
        frame_start();
        draw_line(0, 8, 1'b0);
        draw_line(1, 8, 1'b0);
        for (int c = 0; c < 3; c++) begin
            pbyte(8'hAA, 1'b1, 1'b0, 1'b0);
            pbyte(ypix[2][c], 1'b1, 1'b0, 1'b0);
        end
        begin
            bit seen = 1'b0;
            for (int i = 0; i < 12 && !seen; i++) begin
                @(negedge clk_50);
                if (wr_en0) seen = 1'b1;
            end
            chk("rst_wait_wr_en", seen, 1'b1);
        end
        #1 rst = 1'b1;
        #1;
        chk("arst_wr_en", wr_en0, 1'b0);
        chk("arst_wr_addr", wa0, 16'h0);
        chk("arst_busy", busy0, 1'b0);
        chk("arst_frame_done", fd0, 1'b0);
        tick(2);
        rst = 1'b0;
        repeat (3) pbyte(8'h00, 1'b0, 1'b0, 1'b0);
        clear_obs();
        drive_frame(8, 8, 1'b0, -1);
        check_frame("after_rst", 1'b0, 8, 8, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
